fpu_seq_ctrl: RTL

- Multicycle sequencer for the floating-point datapath. Started by the main control FSM while it is in its FPU-execute state.
- Drives operand capture, execute, normalize and writeback enables for add/sub/mul/div, each with a fixed parameterised latency.
- Holds the main FSM through `stall` until the result is written to the register file via `FPUW`.

---
 rtl/fpu_pkg.sv | 42 ++++
 rtl/fpu_lat_counter.sv | 25 ++
 rtl/fpu_seq_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU sequencer: op codes, state codes, default latencies.
package fpu_pkg;

  localparam logic [1:0] FOP_ADD = 2'd0;
  localparam logic [1:0] FOP_SUB = 2'd1;
  localparam logic [1:0] FOP_MUL = 2'd2;
  localparam logic [1:0] FOP_DIV = 2'd3;

  localparam int unsigned LAT_ADD_DEF = 2;
  localparam int unsigned LAT_MUL_DEF = 3;
  localparam int unsigned LAT_DIV_DEF = 12;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_LATCH = 4'd1;
  localparam logic [3:0] ST_EXEC  = 4'd2;
  localparam logic [3:0] ST_NORM  = 4'd3;
  localparam logic [3:0] ST_WB    = 4'd4;
  localparam logic [3:0] ST_ERR   = 4'd5;

  typedef enum logic [3:0] {
    StIdle  = ST_IDLE,
    StLatch = ST_LATCH,
    StExec  = ST_EXEC,
    StNorm  = ST_NORM,
    StWb    = ST_WB,
    StErr   = ST_ERR
  } fpu_state_e;

  typedef struct packed {
    logic op_latch;
    logic exec_en;
    logic norm_en;
    logic fpuw;
    logic done;
  } fpu_ctrl_t;

  // Counter preload: EXEC runs for (count + 1) cycles.
  function automatic logic [3:0] lat_m1(input int unsigned lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable 4-bit down-counter that holds at zero.
module fpu_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 4'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Multicycle FPU sequencer: LATCH -> EXEC (per-op latency) -> NORM -> WB.
// Optional FPU_EXC_TRAP_EN adds an ERR state and exc_trap output instead of writing back.
module fpu_seq_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD = LAT_ADD_DEF,
  parameter int unsigned LAT_MUL = LAT_MUL_DEF,
  parameter int unsigned LAT_DIV = LAT_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] fop,
  input  logic       flush,
  input  logic       dp_exc,
  output logic       OpLatch,
  output logic       ExecEn,
  output logic [1:0] FpOp,
  output logic       NormEn,
  output logic       FPUW,
  output logic       busy,
  output logic       stall,
  output logic       done,
  output logic       exc_sticky,
  output logic       err_overrun
`ifdef FPU_EXC_TRAP_EN
  ,
  output logic       exc_trap
`endif
);

  fpu_state_e state_q, state_d;
  logic [1:0] fop_q;
  logic       overrun_q, exc_q;
  logic [3:0] lat_load;
  logic       cnt_zero;
  fpu_ctrl_t  ctrl;

  always_comb begin
    lat_load = lat_m1(LAT_ADD);
    unique case (fop_q)
      FOP_MUL: lat_load = lat_m1(LAT_MUL);
      FOP_DIV: lat_load = lat_m1(LAT_DIV);
      default: lat_load = lat_m1(LAT_ADD);
    endcase
  end

  fpu_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == StLatch),
    .load_val (lat_load),
    .dec      (state_q == StExec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLatch;
      StLatch: state_d = StExec;
      StExec:  if (cnt_zero) state_d = StNorm;
`ifdef FPU_EXC_TRAP_EN
      StNorm:  state_d = dp_exc ? StErr : StWb;
      StErr:   state_d = StIdle;
`else
      StNorm:  state_d = StWb;
`endif
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      fop_q     <= FOP_ADD;
      overrun_q <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && start && !flush) fop_q <= fop;
      if (start && (state_q != StIdle)) overrun_q <= 1'b1;
      if ((state_q == StNorm) && dp_exc) exc_q <= 1'b1;
    end
  end

  // A flush in the WB/ERR cycle must also kill the write and completion pulse.
  always_comb begin
    ctrl = '0;
    case (state_q)
      StLatch: ctrl.op_latch = 1'b1;
      StExec:  ctrl.exec_en  = 1'b1;
      StNorm:  ctrl.norm_en  = 1'b1;
      StWb: begin
        ctrl.fpuw = 1'b1;
        ctrl.done = 1'b1;
      end
`ifdef FPU_EXC_TRAP_EN
      StErr:   ctrl.done = 1'b1;
`endif
      default: ctrl = '0;
    endcase
    if (flush) begin
      ctrl.fpuw = 1'b0;
      ctrl.done = 1'b0;
    end
  end

  assign OpLatch     = ctrl.op_latch;
  assign ExecEn      = ctrl.exec_en;
  assign NormEn      = ctrl.norm_en;
  assign FPUW        = ctrl.fpuw;
  assign done        = ctrl.done;
  assign FpOp        = fop_q;
  assign busy        = (state_q != StIdle);
  assign stall       = start | busy;
  assign exc_sticky  = exc_q;
  assign err_overrun = overrun_q;
`ifdef FPU_EXC_TRAP_EN
  assign exc_trap    = (state_q == StErr) && !flush;
`endif

endmodule
